// File: rtl/pmic_pkg.sv
// Shared types and constants for the multiphase PMIC controller.
package pmic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    READ,
    UPDATE
  } adcState_t;

  localparam int unsigned BUSY_TIMEOUT = 64;
  localparam int unsigned READ_CYCLES  = 2;
  localparam int unsigned TIMER_W      = 7;

  // Counter offset that interleaves phase p evenly across the PWM period.
  function automatic int unsigned phaseOffset(input int unsigned width,
                                              input int unsigned phases,
                                              input int unsigned p);
    return (p << width) / phases;
  endfunction

endpackage

// File: rtl/pmic_phase.sv
// One power phase: PWM compare, dead-time insertion and HS/LS gate drive.
module pmic_phase
  import pmic_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned OFFSET   = 0,
  parameter int          DEADTIME = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             kill,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] duty,
  output logic             syncRectifierHs,
  output logic             syncRectifierLs
);

  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] deadCnt;
  logic             hsReq;
  logic             reqQ;
  logic             hsQ;
  logic             lsQ;

  assign compare = counter + WIDTH'(OFFSET);
  assign hsReq   = compare < duty;

  // Both sides are idle (after reset or a kill) are treated like a request
  // edge, so the phase always re-enters through a full dead-time gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqQ    <= 1'b0;
      deadCnt <= '0;
      hsQ     <= 1'b0;
      lsQ     <= 1'b0;
    end else if (kill) begin
      deadCnt <= '0;
      hsQ     <= 1'b0;
      lsQ     <= 1'b0;
    end else if (tick) begin
      if ((hsReq != reqQ) || (!hsQ && !lsQ && deadCnt == '0)) begin
        reqQ <= hsReq;
        if (DEADTIME == 0) begin
          hsQ <= hsReq;
          lsQ <= !hsReq;
        end else begin
          hsQ     <= 1'b0;
          lsQ     <= 1'b0;
          deadCnt <= WIDTH'(DEADTIME);
        end
      end else if (deadCnt != '0) begin
        deadCnt <= deadCnt - 1'b1;
        if (deadCnt == WIDTH'(1)) begin
          hsQ <= reqQ;
          lsQ <= !reqQ;
        end
      end
    end
  end

  // Kill masks the drive combinationally so gates drop in the same cycle.
  assign syncRectifierHs = hsQ & ~kill;
  assign syncRectifierLs = lsQ & ~kill;

endmodule

// File: rtl/pmic_multiphase.sv
// Multiphase buck controller: PWM timebase, ADC sequencing, duty regulation.
module pmic_multiphase
  import pmic_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PHASES   = 2,
  parameter int DIV      = 4,
  parameter int DEADTIME = 2,
  parameter int DMAX     = (1 << WIDTH) - 16,
  parameter int OVP      = (1 << WIDTH) - 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              busy,
  input  logic [WIDTH-1:0]  adcVoltage,
  input  logic [WIDTH-1:0]  vref,
  output logic              convStart,
  output logic              rd_cs,
  output logic [PHASES-1:0] syncRectifierHs,
  output logic [PHASES-1:0] syncRectifierLs,
  output logic [WIDTH-1:0]  duty,
  output logic              fault
);

  localparam int               DIV_W     = $clog2(DIV);
  localparam logic [WIDTH-1:0] DMAX_CODE = WIDTH'(DMAX);
  localparam logic [WIDTH-1:0] OVP_CODE  = WIDTH'(OVP);

  logic [DIV_W-1:0]   divCnt;
  logic               tick;
  logic [WIDTH-1:0]   counter;
  logic               wrap;
  logic               kill;
  adcState_t          state;
  adcState_t          stateNext;
  logic [TIMER_W-1:0] timer;
  logic               timeoutHit;
  logic               readLast;
  logic [WIDTH-1:0]   sample;
  logic [WIDTH-1:0]   dutyNext;

  assign tick       = divCnt == DIV_W'(DIV - 1);
  assign wrap       = tick && (counter == '1);
  assign kill       = fault | ~enable;
  assign timeoutHit = timer == TIMER_W'(BUSY_TIMEOUT - 1);
  assign readLast   = timer == TIMER_W'(READ_CYCLES - 1);

  // Clock-enable divider and free-running PWM counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt  <= '0;
      counter <= '0;
    end else begin
      divCnt <= tick ? '0 : divCnt + 1'b1;
      if (tick) counter <= counter + 1'b1;
    end
  end

  // ADC state register, per-state cycle timer, sample, duty and fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      sample   <= '0;
      duty     <= '0;
      dutyNext <= '0;
      fault    <= 1'b0;
    end else begin
      state <= stateNext;
      timer <= (stateNext != state) ? '0 : timer + 1'b1;
      if (state == READ && readLast) sample <= adcVoltage;
      if (!enable) begin
        fault    <= 1'b0;
        duty     <= '0;
        dutyNext <= '0;
      end else begin
        if (wrap) duty <= dutyNext;
        if (state == WAIT_BUSY && !busy && timeoutHit) fault <= 1'b1;
        if (state == UPDATE) begin
          if (sample >= OVP_CODE) begin
            fault    <= 1'b1;
            duty     <= '0;
            dutyNext <= '0;
          end else if (sample < vref) begin
            dutyNext <= (dutyNext >= DMAX_CODE) ? DMAX_CODE : dutyNext + 1'b1;
          end else if (sample > vref) begin
            dutyNext <= (dutyNext == '0) ? '0 : dutyNext - 1'b1;
          end
        end
      end
    end
  end

  // ADC sequencing next-state and strobes.
  always_comb begin
    stateNext = state;
    convStart = 1'b0;
    rd_cs     = 1'b1;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:      if (wrap && !fault) stateNext = START;
        START: begin
          convStart = 1'b1;
          stateNext = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (busy)            stateNext = WAIT_DONE;
          else if (timeoutHit) stateNext = IDLE;
        end
        WAIT_DONE: if (!busy) stateNext = READ;
        READ: begin
          rd_cs = 1'b0;
          if (readLast) stateNext = UPDATE;
        end
        UPDATE:    stateNext = IDLE;
        default:   stateNext = IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < PHASES; p++) begin : gPhase
    pmic_phase #(
      .WIDTH   (WIDTH),
      .OFFSET  (phaseOffset(WIDTH, PHASES, p)),
      .DEADTIME(DEADTIME)
    ) uPhase (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .kill           (kill),
      .counter        (counter),
      .duty           (duty),
      .syncRectifierHs(syncRectifierHs[p]),
      .syncRectifierLs(syncRectifierLs[p])
    );
  end

endmodule

// File: tb/tb_pmic_multiphase.sv
// Scoreboard bench for pmic_multiphase: duty sequence, PWM timing, faults, reset.
module tb_pmic_multiphase;

  localparam int WIDTH    = 8;
  localparam int PHASES   = 2;
  localparam int DIV      = 4;
  localparam int DEADTIME = 2;
  localparam int DMAX     = 8;
  localparam int OVP      = 248;
  localparam int PERIOD   = 256 * DIV;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              busy;
  logic [WIDTH-1:0]  adcVoltage;
  logic [WIDTH-1:0]  vref;
  logic              convStart;
  logic              rd_cs;
  logic [PHASES-1:0] syncRectifierHs;
  logic [PHASES-1:0] syncRectifierLs;
  logic [WIDTH-1:0]  duty;
  logic              fault;

  pmic_multiphase #(
    .WIDTH   (WIDTH),
    .PHASES  (PHASES),
    .DIV     (DIV),
    .DEADTIME(DEADTIME),
    .DMAX    (DMAX),
    .OVP     (OVP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .busy           (busy),
    .adcVoltage     (adcVoltage),
    .vref           (vref),
    .convStart      (convStart),
    .rd_cs          (rd_cs),
    .syncRectifierHs(syncRectifierHs),
    .syncRectifierLs(syncRectifierLs),
    .duty           (duty),
    .fault          (fault)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int dutyQ[$];
  bit noBusy      = 0;
  int overlapErr  = 0;
  int rdcsErr     = 0;
  int convCount   = 0;
  int lowRun      = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      0:       return syncRectifierHs[0];
      1:       return syncRectifierLs[0];
      2:       return syncRectifierHs[1];
      3:       return convStart;
      4:       return fault;
      default: return rd_cs;
    endcase
  endfunction

  // Wait (sampling at negedge) for a signal level; expiry is a failed check.
  task automatic waitSig(input string name, input int which, input logic lvl,
                         input int limit, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sigSel(which) !== lvl && n < limit);
    t = cyc;
    if (sigSel(which) !== lvl) check(name, int'(sigSel(which)), int'(lvl));
  endtask

  task automatic waitQueue(input string name, input int limit);
    int n = 0;
    while (dutyQ.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (dutyQ.size() != 0) check(name, dutyQ.size(), 0);
  endtask

  // ADC model: busy rises 3 cycles after convStart and lasts 5 cycles.
  initial begin
    busy = 0;
    forever begin
      @(negedge clk);
      if (convStart && !noBusy) begin
        repeat (3) @(negedge clk);
        busy = 1;
        repeat (5) @(negedge clk);
        busy = 0;
      end
    end
  end

  // Monitor: duty scoreboard plus gate-overlap and rd_cs width invariants.
  initial begin
    logic [WIDTH-1:0] lastDuty;
    lastDuty = '0;
    forever begin
      @(negedge clk);
      if (duty !== lastDuty) begin
        if (dutyQ.size() == 0) check("duty_unexpected_change", int'(duty), int'(lastDuty));
        else                   check("duty_scoreboard", int'(duty), dutyQ.pop_front());
        lastDuty = duty;
      end
      if ((syncRectifierHs & syncRectifierLs) != '0) overlapErr++;
      if (reset) begin
        lowRun = 0;
      end else if (!rd_cs) begin
        lowRun++;
      end else if (lowRun != 0) begin
        convCount++;
        if (lowRun != 2) rdcsErr++;
        lowRun = 0;
      end
    end
  end

  initial begin
    int tLsF, tHsR, tHsF, tLsR, tH1R, tH1F, tS, tF;
    reset      = 1;
    enable     = 1;
    vref       = 8'd100;
    adcVoltage = 8'd80;
    repeat (3) @(negedge clk);
    check("reset_hs", int'(syncRectifierHs), 0);
    check("reset_ls", int'(syncRectifierLs), 0);
    check("reset_convstart", int'(convStart), 0);
    check("reset_rdcs", int'(rd_cs), 1);
    check("reset_duty", int'(duty), 0);
    check("reset_fault", int'(fault), 0);

    // Ramp: sample 80 below vref 100, one step per period up to DMAX.
    for (int i = 1; i <= DMAX; i++) dutyQ.push_back(i);
    reset = 0;
    waitQueue("ramp_drain", 11 * PERIOD);
    repeat (2 * PERIOD) @(negedge clk);
    check("ramp_saturated", int'(duty), DMAX);

    // PWM waveform at duty 8: 6 HS ticks, 2-tick gaps, phase 1 lags 128 ticks.
    waitSig("wait_ls0_high", 1, 1'b1, 2 * PERIOD, tLsF);
    waitSig("wait_ls0_fall", 1, 1'b0, 2 * PERIOD, tLsF);
    waitSig("wait_hs0_rise", 0, 1'b1, 100, tHsR);
    waitSig("wait_hs0_fall", 0, 1'b0, 100, tHsF);
    waitSig("wait_ls0_rise", 1, 1'b1, 100, tLsR);
    waitSig("wait_hs1_rise", 2, 1'b1, PERIOD, tH1R);
    waitSig("wait_hs1_fall", 2, 1'b0, 100, tH1F);
    check("dead_ls_to_hs", tHsR - tLsF, DEADTIME * DIV);
    check("hs0_width", tHsF - tHsR, (DMAX - DEADTIME) * DIV);
    check("dead_hs_to_ls", tLsR - tHsF, DEADTIME * DIV);
    check("phase1_shift", tH1R - tHsR, 128 * DIV);
    check("hs1_width", tH1F - tH1R, (DMAX - DEADTIME) * DIV);

    // Sample above vref steps duty down; equal sample holds it.
    adcVoltage = 8'd120;
    dutyQ.push_back(7);
    dutyQ.push_back(6);
    dutyQ.push_back(5);
    waitQueue("down_drain", 5 * PERIOD);
    adcVoltage = 8'd100;
    repeat (2 * PERIOD) @(negedge clk);
    check("hold_duty", int'(duty), 5);

    // Over-voltage: sticky fault, gates off, duty zero; enable toggle clears.
    dutyQ.push_back(0);
    adcVoltage = 8'd250;
    waitSig("wait_ovp_fault", 4, 1'b1, 2 * PERIOD, tF);
    check("ovp_gates_off", int'({syncRectifierHs, syncRectifierLs}), 0);
    check("ovp_duty", int'(duty), 0);
    repeat (PERIOD + 10) @(negedge clk);
    check("ovp_fault_sticky", int'(fault), 1);
    enable = 0;
    repeat (2) @(negedge clk);
    check("fault_cleared", int'(fault), 0);
    check("disabled_rdcs", int'(rd_cs), 1);
    adcVoltage = 8'd100;
    noBusy     = 1;
    enable     = 1;

    // Busy never rises: fault 64 cycles after WAIT_BUSY entry.
    waitSig("wait_convstart", 3, 1'b1, PERIOD + 100, tS);
    @(negedge clk);
    check("convstart_width", int'(convStart), 0);
    waitSig("wait_timeout_fault", 4, 1'b1, 100, tF);
    check("timeout_latency", tF - tS, 65);
    check("timeout_gates_off", int'({syncRectifierHs, syncRectifierLs}), 0);
    enable = 0;
    repeat (2) @(negedge clk);
    noBusy     = 0;
    adcVoltage = 8'd80;
    dutyQ.push_back(1);
    dutyQ.push_back(2);
    enable = 1;
    waitQueue("reramp_drain", 4 * PERIOD);

    // Reset during READ: outputs go to reset values without a clock edge.
    waitSig("wait_read", 5, 1'b0, PERIOD + 100, tS);
    dutyQ.push_back(0);
    #1 reset = 1;
    #1;
    check("async_rdcs", int'(rd_cs), 1);
    check("async_convstart", int'(convStart), 0);
    check("async_duty", int'(duty), 0);
    check("async_gates", int'({syncRectifierHs, syncRectifierLs}), 0);
    repeat (3) @(negedge clk);
    reset = 0;
    dutyQ.push_back(1);
    waitQueue("post_reset_drain", 3 * PERIOD);
    repeat (4) @(negedge clk);

    check("hs_ls_overlap", overlapErr, 0);
    check("rdcs_low_width", rdcsErr, 0);
    check("conversions_seen", int'(convCount > 10), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pmic_multiphase.md
PMIC_MULTIPHASE -- requirements
Module: pmic_multiphase

Interface
REQ-001 Parameter WIDTH, default 8, ADC sample, duty and PWM counter width in bits.
REQ-002 Parameter PHASES, default 2, number of interleaved power phases (1..8).
REQ-003 Parameter DIV, default 4, clk cycles per PWM tick (>=2).
REQ-004 Parameter DEADTIME, default 2, dead-time in PWM ticks (< 2^WIDTH/4).
REQ-005 Parameter DMAX, default 2^WIDTH-16, maximum duty code.
REQ-006 Parameter OVP, default 2^WIDTH-8, over-voltage ADC code.
REQ-007 clk  in  1  system clock, sole clock domain.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 enable  in  1  regulator run request, level.
REQ-010 busy  in  1  ADC conversion-in-progress flag.
REQ-011 adcVoltage  in  WIDTH  ADC result, valid while rd_cs low.
REQ-012 vref  in  WIDTH  regulation target code.
REQ-013 convStart  out  1  ADC start pulse, active-high.
REQ-014 rd_cs  out  1  ADC read strobe, active-low.
REQ-015 syncRectifierHs  out  PHASES  high-side gate drive per phase, active-high.
REQ-016 syncRectifierLs  out  PHASES  low-side gate drive per phase, active-high.
REQ-017 duty  out  WIDTH  currently applied duty code.
REQ-018 fault  out  1  sticky over-voltage/ADC-timeout flag.

Function
REQ-019 Tick: single-cycle clock enable every DIV clk cycles; no derived clocks.
REQ-020 PWM counter: WIDTH bits, increments on tick, wraps 2^WIDTH-1 -> 0.
REQ-021 Phase p compare value = (counter + p*2^WIDTH/PHASES) mod 2^WIDTH.
REQ-022 Phase p HS request = compare < duty; LS request = NOT HS request.
REQ-023 Every request edge: both outputs of that phase low for DEADTIME ticks, then new side asserts; HS and LS never high together.
REQ-024 duty = 0: HS never asserts; duty updates only on the tick where counter wraps to 0.
REQ-025 ADC FSM states IDLE, START, WAIT_BUSY, WAIT_DONE, READ, UPDATE.
REQ-026 IDLE -> START on counter wrap while enable=1 and fault=0.
REQ-027 START: convStart=1 for exactly one clk cycle, then WAIT_BUSY.
REQ-028 WAIT_BUSY -> WAIT_DONE when busy=1; 64 clk cycles without busy -> fault=1, IDLE.
REQ-029 WAIT_DONE -> READ when busy=0.
REQ-030 READ: rd_cs=0 for 2 clk cycles; adcVoltage sampled on second cycle; then UPDATE.
REQ-031 UPDATE (1 cycle): sample<vref -> next duty+1 saturating at DMAX; sample>vref -> next duty-1 saturating at 0; equal -> hold; then IDLE.
REQ-032 Sample >= OVP in UPDATE: fault=1, next duty=0.
REQ-033 Counter wrap during non-IDLE FSM: ignored, no queued conversion.
REQ-034 fault=1: all HS/LS low within one clk cycle, FSM to IDLE; cleared only by enable=0 or reset.
REQ-035 enable=0: FSM to IDLE, duty=0, all gate outputs low, convStart=0, rd_cs=1, counter keeps running.

Reset
REQ-036 Reset: counter=0, tick divider=0, FSM=IDLE, duty=0, fault=0, convStart=0, rd_cs=1, all HS/LS=0, dead-time counters=0.
REQ-037 Reset mid-conversion abandons it; no rd_cs pulse after release until a new START.

Structure
REQ-038 Package pmic_pkg holds ADC FSM state enum, timeout constant (64) and READ length (2).
REQ-039 Sub-module pmic_phase (compare, dead-time, HS/LS drive) instantiated PHASES times via generate.

Verification
REQ-040 WIDTH=8, PHASES=2, DIV=4, duty forced 128 -> phase1 HS waveform is phase0 shifted 128 ticks; 2-tick dead gaps at each edge.
REQ-041 vref=100, ADC model returns 80 -> duty rises 1 per PWM period, saturates at DMAX=240.
REQ-042 ADC model returns 250 (>=OVP 248) -> fault=1, all gates low next cycle, duty=0; enable toggle clears fault.
REQ-043 busy never asserted after convStart -> fault=1 exactly 64 clk cycles after WAIT_BUSY entry.
REQ-044 reset asserted during READ -> rd_cs=1 and outputs at reset values asynchronously; normal cycle resumes after release.
REQ-045 Every test: checker asserts HS[p] AND LS[p] never both 1 and rd_cs low exactly 2 cycles per conversion.
